// File: rtl/frv_alu_arb_pkg.sv
// Shared constants for the frv ALU arbiter: datapath width, op-vector bit
// indices, pack-width codes, response-slot state encodings.
package frv_alu_arb_pkg;

    localparam int XLEN     = 32;
    localparam int XL       = XLEN - 1;
    localparam int ALU_OP_W = 11;

    // Bit positions inside the op vector.
    localparam int OP_ADD       = 0;
    localparam int OP_SUB       = 1;
    localparam int OP_XOR       = 2;
    localparam int OP_OR        = 3;
    localparam int OP_AND       = 4;
    localparam int OP_SHF       = 5;
    localparam int OP_ROT       = 6;
    localparam int OP_SHF_LEFT  = 7;
    localparam int OP_SHF_ARITH = 8;
    localparam int OP_CMP       = 9;
    localparam int OP_UNSIGNED  = 10;

    localparam logic [2:0] PW_32 = 3'b001;
    localparam logic [2:0] PW_16 = 3'b010;
    localparam logic [2:0] PW_8  = 3'b011;
    localparam logic [2:0] PW_4  = 3'b100;
    localparam logic [2:0] PW_2  = 3'b101;

    localparam int STARVE_LIM = 4;
    localparam int STARVE_W   = 3;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/frv_alu_rsp_slot.sv
// Single-entry tagged response register. Loads on grant, empties on drain by
// the owning port or on a flush kill of a port-0 entry; load wins over both.
module frv_alu_rsp_slot
    import frv_alu_arb_pkg::*;
(
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic          load,
    input  logic          load_id,
    input  logic [XL:0]   load_result,
    input  logic          load_lt,
    input  logic          load_eq,
    input  logic          kill0,
    input  logic          rsp0_ready,
    input  logic          rsp1_ready,
    output logic          free,
    output logic          slot_state,
    output logic          rsp0_valid,
    output logic [XL:0]   rsp0_result,
    output logic          rsp0_lt,
    output logic          rsp0_eq,
    output logic          rsp1_valid,
    output logic [XL:0]   rsp1_result,
    output logic          rsp1_lt,
    output logic          rsp1_eq
);

    slot_state_t state_q, state_d;
    logic        id_q;
    logic [XL:0] result_q;
    logic        lt_q, eq_q;
    logic        full, drain, killed;

    assign full   = (state_q == ARB_FULL);
    assign drain  = full && (id_q ? rsp1_ready : rsp0_ready);
    assign killed = full && !id_q && kill0;
    assign free   = !full || drain || killed;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= ARB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_EMPTY: if (load) state_d = ARB_FULL;
            ARB_FULL: begin
                if (load) begin
                    state_d = ARB_FULL;
                end else if (drain || killed) begin
                    state_d = ARB_EMPTY;
                end
            end
            default: state_d = ARB_EMPTY;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            id_q     <= 1'b0;
            result_q <= '0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
        end else if (load) begin
            id_q     <= load_id;
            result_q <= load_result;
            lt_q     <= load_lt;
            eq_q     <= load_eq;
        end
    end

    // Data outputs are forced to zero for the port that does not own the slot.
    assign slot_state  = full;
    assign rsp0_valid  = full && !id_q;
    assign rsp1_valid  = full && id_q;
    assign rsp0_result = rsp0_valid ? result_q : '0;
    assign rsp0_lt     = rsp0_valid && lt_q;
    assign rsp0_eq     = rsp0_valid && eq_q;
    assign rsp1_result = rsp1_valid ? result_q : '0;
    assign rsp1_lt     = rsp1_valid && lt_q;
    assign rsp1_eq     = rsp1_valid && eq_q;

endmodule

// File: rtl/frv_alu_arb.sv
// Two-port arbiter sharing one combinational ALU, with a tagged 1-cycle response
// slot. FRV_ALU_ARB_RR_EN selects round-robin instead of priority + starvation.
module frv_alu_arb
    import frv_alu_arb_pkg::*;
(
    input  logic                g_clk,
    input  logic                g_reset,
    input  logic                alu_flush,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ALU_OP_W-1:0] req0_op,
    input  logic [2:0]          req0_pw,
    input  logic [XL:0]         req0_lhs,
    input  logic [XL:0]         req0_rhs,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ALU_OP_W-1:0] req1_op,
    input  logic [2:0]          req1_pw,
    input  logic [XL:0]         req1_lhs,
    input  logic [XL:0]         req1_rhs,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [XL:0]         rsp0_result,
    output logic                rsp0_lt,
    output logic                rsp0_eq,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [XL:0]         rsp1_result,
    output logic                rsp1_lt,
    output logic                rsp1_eq,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [2:0]          alu_pw,
    output logic [XL:0]         alu_lhs,
    output logic [XL:0]         alu_rhs,
    input  logic [XL:0]         alu_result,
    input  logic                alu_lt,
    input  logic                alu_eq,
    output logic                dbg_slot_state,
    output logic [STARVE_W-1:0] dbg_starve_cnt
);

    // Handshake: a request transfers in the cycle reqN_valid && reqN_ready; the
    // requester holds its fields while valid && !ready. A response transfers in
    // the cycle rspN_valid && rspN_ready.
    logic free, want0, want1, gnt0, gnt1;

    assign want0 = req0_valid && !alu_flush && !g_reset;
    assign want1 = req1_valid && !g_reset;

`ifdef FRV_ALU_ARB_RR_EN
    logic rr_ptr;

    always_comb begin
        gnt1 = free && want1 && (rr_ptr || !want0);
        gnt0 = free && want0 && !gnt1;
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            rr_ptr <= 1'b0;
        end else if (gnt0) begin
            rr_ptr <= 1'b1;
        end else if (gnt1) begin
            rr_ptr <= 1'b0;
        end
    end

    assign dbg_starve_cnt = '0;
`else
    logic [STARVE_W-1:0] starve_cnt;
    logic                starved;

    assign starved = (starve_cnt == STARVE_W'(STARVE_LIM));

    always_comb begin
        gnt1 = free && want1 && (starved || !want0);
        gnt0 = free && want0 && !gnt1;
    end

    // Counts every cycle port 1 waits, including cycles the slot is busy.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            starve_cnt <= '0;
        end else if (req1_valid && !gnt1) begin
            if (!starved) starve_cnt <= starve_cnt + STARVE_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    assign dbg_starve_cnt = starve_cnt;
`endif

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        alu_op  = '0;
        alu_pw  = '0;
        alu_lhs = '0;
        alu_rhs = '0;
        if (gnt0) begin
            alu_op  = req0_op;
            alu_pw  = req0_pw;
            alu_lhs = req0_lhs;
            alu_rhs = req0_rhs;
        end else if (gnt1) begin
            alu_op  = req1_op;
            alu_pw  = req1_pw;
            alu_lhs = req1_lhs;
            alu_rhs = req1_rhs;
        end
    end

    frv_alu_rsp_slot u_slot (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .load        (gnt0 || gnt1),
        .load_id     (gnt1),
        .load_result (alu_result),
        .load_lt     (alu_lt),
        .load_eq     (alu_eq),
        .kill0       (alu_flush),
        .rsp0_ready  (rsp0_ready),
        .rsp1_ready  (rsp1_ready),
        .free        (free),
        .slot_state  (dbg_slot_state),
        .rsp0_valid  (rsp0_valid),
        .rsp0_result (rsp0_result),
        .rsp0_lt     (rsp0_lt),
        .rsp0_eq     (rsp0_eq),
        .rsp1_valid  (rsp1_valid),
        .rsp1_result (rsp1_result),
        .rsp1_lt     (rsp1_lt),
        .rsp1_eq     (rsp1_eq)
    );

endmodule

// File: tb/tb_frv_alu_arb.sv
// Bench for frv_alu_arb: behavioural ALU + arbiter model checked every cycle,
// plus directed scenarios with literal expectations. Honours FRV_ALU_ARB_RR_EN.
module tb_frv_alu_arb;
    import frv_alu_arb_pkg::*;

    logic                g_clk = 1'b0;
    logic                g_reset, alu_flush;
    logic                req0_valid, req0_ready, req1_valid, req1_ready;
    logic [ALU_OP_W-1:0] req0_op, req1_op, alu_op;
    logic [2:0]          req0_pw, req1_pw, alu_pw;
    logic [XL:0]         req0_lhs, req0_rhs, req1_lhs, req1_rhs;
    logic                rsp0_valid, rsp0_ready, rsp0_lt, rsp0_eq;
    logic                rsp1_valid, rsp1_ready, rsp1_lt, rsp1_eq;
    logic [XL:0]         rsp0_result, rsp1_result;
    logic [XL:0]         alu_lhs, alu_rhs, alu_result;
    logic                alu_lt, alu_eq;
    logic                dbg_slot_state;
    logic [STARVE_W-1:0] dbg_starve_cnt;

    localparam logic [ALU_OP_W-1:0] V_ADD = ALU_OP_W'(1) << OP_ADD;
    localparam logic [ALU_OP_W-1:0] V_SUB = ALU_OP_W'(1) << OP_SUB;
    localparam logic [ALU_OP_W-1:0] V_XOR = ALU_OP_W'(1) << OP_XOR;
    localparam logic [ALU_OP_W-1:0] V_SHF = ALU_OP_W'(1) << OP_SHF;
    localparam logic [ALU_OP_W-1:0] V_LFT = ALU_OP_W'(1) << OP_SHF_LEFT;
    localparam logic [ALU_OP_W-1:0] V_CMP = ALU_OP_W'(1) << OP_CMP;
    localparam logic [ALU_OP_W-1:0] V_UNS = ALU_OP_W'(1) << OP_UNSIGNED;

    int total = 0;
    int bad   = 0;

    frv_alu_arb dut (
        .g_clk(g_clk), .g_reset(g_reset), .alu_flush(alu_flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_pw(req0_pw), .req0_lhs(req0_lhs), .req0_rhs(req0_rhs),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_pw(req1_pw), .req1_lhs(req1_lhs), .req1_rhs(req1_rhs),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_lt(rsp0_lt), .rsp0_eq(rsp0_eq),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_lt(rsp1_lt), .rsp1_eq(rsp1_eq),
        .alu_op(alu_op), .alu_pw(alu_pw), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_result(alu_result), .alu_lt(alu_lt), .alu_eq(alu_eq),
        .dbg_slot_state(dbg_slot_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference ALU: returns {result, lt, eq}.
    function automatic logic [XLEN+1:0] alu_fn(input logic [ALU_OP_W-1:0] op,
                                               input logic [XL:0] a, input logic [XL:0] b);
        logic [XL:0] r;
        logic        lt, eq;
        lt = op[OP_UNSIGNED] ? (a < b) : ($signed(a) < $signed(b));
        eq = (a == b);
        r  = '0;
        if (op[OP_CMP])                                   r = {{XL{1'b0}}, lt};
        else if (op[OP_ADD])                              r = a + b;
        else if (op[OP_SUB])                              r = a - b;
        else if (op[OP_XOR])                              r = a ^ b;
        else if (op[OP_OR])                               r = a | b;
        else if (op[OP_AND])                              r = a & b;
        else if (op[OP_SHF] && op[OP_SHF_LEFT])           r = a << b[4:0];
        else if (op[OP_SHF] && op[OP_SHF_ARITH])          r = $signed(a) >>> b[4:0];
        else if (op[OP_SHF])                              r = a >> b[4:0];
        return {r, lt, eq};
    endfunction

    always_comb {alu_result, alu_lt, alu_eq} = alu_fn(alu_op, alu_lhs, alu_rhs);

    // Behavioural model state: contents of the response slot and the wait history.
    bit               m_full, m_id, m_rr;
    logic [XL:0]      m_res;
    logic             m_lt, m_eq;
    int               m_lost;
    logic             e_free, e_g0, e_g1, e_pick1;
    logic [XLEN+1:0]  e_f;

    always @(negedge g_clk) begin
        if (g_reset) begin
            m_full = 0; m_id = 0; m_rr = 0; m_lost = 0;
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            chk("rst_starve", dbg_starve_cnt, 0);
        end else begin
            chk("m_rsp0_valid",  rsp0_valid,  m_full && !m_id);
            chk("m_rsp1_valid",  rsp1_valid,  m_full && m_id);
            chk("m_rsp0_result", rsp0_result, (m_full && !m_id) ? m_res : '0);
            chk("m_rsp1_result", rsp1_result, (m_full && m_id) ? m_res : '0);
            chk("m_rsp0_flags",  {rsp0_lt, rsp0_eq}, (m_full && !m_id) ? {m_lt, m_eq} : 2'b00);
            chk("m_rsp1_flags",  {rsp1_lt, rsp1_eq}, (m_full && m_id) ? {m_lt, m_eq} : 2'b00);
            chk("m_slot_state",  dbg_slot_state, m_full);
`ifdef FRV_ALU_ARB_RR_EN
            chk("m_starve", dbg_starve_cnt, 0);
            e_pick1 = m_rr;
`else
            chk("m_starve", dbg_starve_cnt, m_lost);
            e_pick1 = (m_lost >= STARVE_LIM);
`endif
            e_free = !m_full || (m_id ? rsp1_ready : (rsp0_ready || alu_flush));
            e_g1 = e_free && req1_valid && (e_pick1 || !(req0_valid && !alu_flush));
            e_g0 = e_free && req0_valid && !alu_flush && !e_g1;
            chk("m_req0_ready", req0_ready, e_g0);
            chk("m_req1_ready", req1_ready, e_g1);
            chk("m_alu_op",  alu_op,  e_g0 ? req0_op  : e_g1 ? req1_op  : '0);
            chk("m_alu_pw",  alu_pw,  e_g0 ? req0_pw  : e_g1 ? req1_pw  : '0);
            chk("m_alu_lhs", alu_lhs, e_g0 ? req0_lhs : e_g1 ? req1_lhs : '0);
            chk("m_alu_rhs", alu_rhs, e_g0 ? req0_rhs : e_g1 ? req1_rhs : '0);
            // Advance the model to what the next edge must produce.
            if (e_g0 || e_g1) begin
                e_f = e_g1 ? alu_fn(req1_op, req1_lhs, req1_rhs) : alu_fn(req0_op, req0_lhs, req0_rhs);
                {m_res, m_lt, m_eq} = e_f;
                m_full = 1;
                m_id   = e_g1;
                m_rr   = e_g0;
            end else if (e_free) begin
                m_full = 0;
            end
            if (req1_valid && !e_g1) m_lost = (m_lost < STARVE_LIM) ? m_lost + 1 : STARVE_LIM;
            else m_lost = 0;
        end
    end

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [ALU_OP_W-1:0] op,
                          input logic [XL:0] a, input logic [XL:0] b);
        req0_valid = v; req0_op = op; req0_pw = PW_32; req0_lhs = a; req0_rhs = b;
    endtask

    task automatic drive1(input logic v, input logic [ALU_OP_W-1:0] op,
                          input logic [XL:0] a, input logic [XL:0] b);
        req1_valid = v; req1_op = op; req1_pw = PW_16; req1_lhs = a; req1_rhs = b;
    endtask

    int gseq[8];
    int exp2[8];

    initial begin
        g_reset = 1; alu_flush = 0; rsp0_ready = 0; rsp1_ready = 0;
        drive0(1, V_ADD, 5, 7);
        drive1(0, '0, '0, '0);
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        chk("reset_ready0_gated", req0_ready, 0);
        chk("reset_slot_empty", rsp0_valid, 0);
        cyc();
        g_reset = 0; req0_valid = 0;

        // 1: lone add, granted combinationally, result one edge later
        cyc();
        drive0(1, V_ADD, 5, 7); rsp0_ready = 1;
        @(negedge g_clk);
        chk("t1_ready0", req0_ready, 1);
        cyc();
        req0_valid = 0;
        @(negedge g_clk);
        chk("t1_rsp0_result", rsp0_result, 12);
        chk("t1_rsp0_valid", rsp0_valid, 1);

        // 2: both ports contend continuously
        cyc();
        drive0(1, V_ADD, 1, 2); drive1(1, V_ADD, 10, 20); rsp1_ready = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge g_clk);
            gseq[i] = req1_ready ? 1 : (req0_ready ? 0 : 2);
            cyc();
        end
        req0_valid = 0; req1_valid = 0;
`ifdef FRV_ALU_ARB_RR_EN
        // the grant in test 1 left port 1 preferred
        exp2 = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
        exp2 = '{0, 0, 0, 0, 1, 0, 0, 0};
`endif
        for (int i = 0; i < 8; i++) chk($sformatf("t2_grant%0d", i), gseq[i], exp2[i]);

        // 3: port-1 result held while not consumed; port 0 blocked meanwhile
        rsp1_ready = 0;
        drive1(1, V_SUB, 3, 5);
        @(negedge g_clk);
        chk("t3_ready1", req1_ready, 1);
        cyc();
        req1_valid = 0;
        drive0(1, V_ADD, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge g_clk);
            chk("t3_hold_result", rsp1_result, 32'hFFFF_FFFE);
            chk("t3_ready0_blocked", req0_ready, 0);
            cyc();
        end
        rsp1_ready = 1;
        @(negedge g_clk);
        chk("t3_resume_ready0", req0_ready, 1);
        cyc();
        req0_valid = 0;
        @(negedge g_clk);
        chk("t3_rsp0_result", rsp0_result, 2);

        // 4: flush kills a port-0 entry and lets port 1 in the same cycle
        cyc();
        rsp0_ready = 0;
        drive0(1, V_ADD, 0, 9);
        @(negedge g_clk);
        cyc();
        alu_flush = 1;
        drive1(1, V_XOR, 32'hF0, 32'hFF);
        @(negedge g_clk);
        chk("t4_ready0_flushed", req0_ready, 0);
        chk("t4_ready1", req1_ready, 1);
        chk("t4_rsp0_before_kill", rsp0_result, 9);
        cyc();
        alu_flush = 0; req0_valid = 0; req1_valid = 0;
        @(negedge g_clk);
        chk("t4_rsp1_result", rsp1_result, 32'h0F);
        chk("t4_rsp0_valid", rsp0_valid, 0);

        // 5: signed then unsigned compare, back to back
        cyc();
        rsp0_ready = 1;
        drive0(1, V_CMP, 32'hFFFF_FFFF, 1);
        @(negedge g_clk);
        cyc();
        drive0(1, V_CMP | V_UNS, 32'hFFFF_FFFF, 1);
        @(negedge g_clk);
        chk("t5_signed_result", rsp0_result, 1);
        chk("t5_signed_lt", rsp0_lt, 1);
        cyc();
        req0_valid = 0;
        @(negedge g_clk);
        chk("t5_unsigned_result", rsp0_result, 0);
        chk("t5_unsigned_lt", rsp0_lt, 0);

        // 6: asynchronous reset with a full slot and a waiting port 1
        cyc();
        rsp0_ready = 0; rsp1_ready = 0;
        drive0(1, V_ADD, 100, 23);
        drive1(1, V_ADD, 1, 1);
        repeat (3) begin
            @(negedge g_clk);
            cyc();
        end
        chk("t6_full_before", rsp0_valid | rsp1_valid, 1);
`ifdef FRV_ALU_ARB_RR_EN
        chk("t6_starve_before", dbg_starve_cnt, 0);
`else
        chk("t6_starve_before", dbg_starve_cnt, 3);
`endif
        g_reset = 1;
        #1;
        chk("t6_rsp0_valid", rsp0_valid, 0);
        chk("t6_rsp1_valid", rsp1_valid, 0);
        chk("t6_rsp0_result", rsp0_result, 0);
        chk("t6_starve", dbg_starve_cnt, 0);
        cyc();
        g_reset = 0; req0_valid = 0; req1_valid = 0;

        // post-reset sanity: left shift through port 0
        cyc();
        rsp0_ready = 1;
        drive0(1, V_SHF | V_LFT, 1, 4);
        @(negedge g_clk);
        cyc();
        req0_valid = 0;
        @(negedge g_clk);
        chk("post_shift_result", rsp0_result, 16);
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
